// File: rtl/icache_way_ram.sv
// icache_way_ram: N-way set-associative I-cache tag/data/valid store with
// registered lookup, per-set round-robin victim pointer and invalidate sweep.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ready                      array idle (low while sweeping)
//   lookup_en/index/tag        lookup request
//   rd_valid/hit/hit_way/rd_line/victim_way   registered lookup result
//   fill_en/index/way/tag/line refill write
//   inv_en/inv_index           invalidate one set
//   inv_all                    start full invalidate sweep
//   hit_cnt/miss_cnt           perf counters (only with ICACHE_PERF_CNT_EN)
//
// Optional feature macro: ICACHE_PERF_CNT_EN

module icache_way_ram #(
    parameter int INDEX_SIZE    = 6,
    parameter int WORD_OFF_SIZE = 4,
    parameter int TAG_SIZE      = 20,
    parameter int WAYS          = 2,
    localparam int SETS         = 2 ** INDEX_SIZE,
    localparam int LINE_BITS    = 32 * (2 ** WORD_OFF_SIZE),
    localparam int WAY_BITS     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  lookup_en,
    input  logic [INDEX_SIZE-1:0] lookup_index,
    input  logic [TAG_SIZE-1:0]   lookup_tag,
    output logic                  rd_valid,
    output logic                  hit,
    output logic [WAY_BITS-1:0]   hit_way,
    output logic [LINE_BITS-1:0]  rd_line,
    output logic [WAY_BITS-1:0]   victim_way,
    input  logic                  fill_en,
    input  logic [INDEX_SIZE-1:0] fill_index,
    input  logic [WAY_BITS-1:0]   fill_way,
    input  logic [TAG_SIZE-1:0]   fill_tag,
    input  logic [LINE_BITS-1:0]  fill_line,
    input  logic                  inv_en,
    input  logic [INDEX_SIZE-1:0] inv_index,
    input  logic                  inv_all
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    typedef enum logic {
        SWEEP,
        IDLE
    } state_e;

    localparam logic [INDEX_SIZE-1:0] LAST_SET = INDEX_SIZE'(SETS - 1);

    state_e                  state_q;
    logic [INDEX_SIZE-1:0]   cnt_q;
    logic                    rd_valid_q;
    logic                    hit_q;
    logic [WAY_BITS-1:0]     hit_way_q;
    logic [LINE_BITS-1:0]    line_q;
    logic [WAY_BITS-1:0]     victim_q;

    logic [WAYS-1:0]         valid_q [SETS];
    logic [WAY_BITS-1:0]     ptr_q   [SETS];
    logic [TAG_SIZE-1:0]     tag_q   [WAYS][SETS];
    logic [LINE_BITS-1:0]    data_q  [WAYS][SETS];

    logic                    hit_d;
    logic [WAY_BITS-1:0]     hit_way_d;
    logic [LINE_BITS-1:0]    line_d;
    logic [WAY_BITS-1:0]     ptr_d;

    logic                    acc_lookup;
    logic                    do_fill;
    logic                    do_inv;
    logic                    sweep_clr;

    assign ready      = (state_q == IDLE);
    assign rd_valid   = rd_valid_q;
    assign hit        = hit_q;
    assign hit_way    = hit_way_q;
    assign rd_line    = line_q;
    assign victim_way = victim_q;

    // inv_all takes priority over single-set writes in the same cycle.
    assign acc_lookup = ready && lookup_en && !reset;
    assign do_fill    = ready && fill_en && !inv_all && !reset;
    assign do_inv     = ready && inv_en && !inv_all && !reset;
    assign sweep_clr  = (state_q == SWEEP) && !reset;

    assign ptr_d = (WAYS == 1) ? '0 : WAY_BITS'(fill_way + WAY_BITS'(1));

    // Scan high to low so the lowest matching way is the one kept.
    always_comb begin
        hit_d     = 1'b0;
        hit_way_d = '0;
        line_d    = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lookup_index][w] &&
                tag_q[w][lookup_index] == lookup_tag) begin
                hit_d     = 1'b1;
                hit_way_d = WAY_BITS'(w);
                line_d    = data_q[w][lookup_index];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SWEEP;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            hit_q      <= 1'b0;
            hit_way_q  <= '0;
            victim_q   <= '0;
        end else begin
            rd_valid_q <= acc_lookup;
            hit_q      <= acc_lookup && hit_d;
            if (acc_lookup) begin
                hit_way_q <= hit_way_d;
                victim_q  <= ptr_q[lookup_index];
            end
            if (inv_all) begin
                state_q <= SWEEP;
                cnt_q   <= '0;
            end else if (state_q == SWEEP) begin
                if (cnt_q == LAST_SET) begin
                    state_q <= IDLE;
                end
                cnt_q <= cnt_q + INDEX_SIZE'(1);
            end
        end
    end

    // Line data is don't-care when rd_valid is low, so it carries no reset.
    always_ff @(posedge clk) begin
        if (acc_lookup) begin
            line_q <= line_d;
        end
    end

    // Statement order matters: an invalidate of the same set as a fill
    // lands last, so the set ends up invalid.
    always_ff @(posedge clk) begin
        if (sweep_clr) begin
            valid_q[cnt_q] <= '0;
            ptr_q[cnt_q]   <= '0;
        end
        if (do_fill) begin
            valid_q[fill_index][fill_way] <= 1'b1;
            ptr_q[fill_index]             <= ptr_d;
        end
        if (do_inv) begin
            valid_q[inv_index] <= '0;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        always_ff @(posedge clk) begin
            if (do_fill && fill_way == WAY_BITS'(w)) begin
                tag_q[w][fill_index]  <= fill_tag;
                data_q[w][fill_index] <= fill_line;
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || inv_all) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rd_valid_q) begin
            if (hit_q) begin
                if (hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end
            end else begin
                if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_way_ram.sv
// tb_icache_way_ram: directed vectors for icache_way_ram (WAYS=2, 64 sets).
// Perf counter vectors are compiled in with ICACHE_PERF_CNT_EN.

module tb_icache_way_ram;

    logic         clk = 1'b0;
    logic         reset;
    logic         ready;
    logic         lookup_en;
    logic [5:0]   lookup_index;
    logic [19:0]  lookup_tag;
    logic         rd_valid;
    logic         hit;
    logic [0:0]   hit_way;
    logic [511:0] rd_line;
    logic [0:0]   victim_way;
    logic         fill_en;
    logic [5:0]   fill_index;
    logic [0:0]   fill_way;
    logic [19:0]  fill_tag;
    logic [511:0] fill_line;
    logic         inv_en;
    logic [5:0]   inv_index;
    logic         inv_all;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [511:0] L0 = {8{64'h0123_4567_89AB_CDEF}};
    localparam logic [511:0] L1 = {16{32'hDEAD_BEEF}};
    localparam logic [511:0] L2 = {16{32'h5A5A_0F0F}};

    icache_way_ram dut (
        .clk          (clk),
        .reset        (reset),
        .ready        (ready),
        .lookup_en    (lookup_en),
        .lookup_index (lookup_index),
        .lookup_tag   (lookup_tag),
        .rd_valid     (rd_valid),
        .hit          (hit),
        .hit_way      (hit_way),
        .rd_line      (rd_line),
        .victim_way   (victim_way),
        .fill_en      (fill_en),
        .fill_index   (fill_index),
        .fill_way     (fill_way),
        .fill_tag     (fill_tag),
        .fill_line    (fill_line),
        .inv_en       (inv_en),
        .inv_index    (inv_index),
        .inv_all      (inv_all)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [5:0] idx, input logic [19:0] tag);
        lookup_en    = 1'b1;
        lookup_index = idx;
        lookup_tag   = tag;
        tick();
        lookup_en = 1'b0;
        chk("rd_valid", rd_valid, 1);
    endtask

    task automatic fill(input logic [5:0] idx, input logic w,
                        input logic [19:0] tag, input logic [511:0] line);
        fill_en    = 1'b1;
        fill_index = idx;
        fill_way   = w;
        fill_tag   = tag;
        fill_line  = line;
        tick();
        fill_en = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        chk(tag, n, 64);
    endtask

    initial begin
        reset = 1'b1;
        lookup_en = 0; lookup_index = 0; lookup_tag = 0;
        fill_en = 0; fill_index = 0; fill_way = 0;
        fill_tag = 0; fill_line = 0;
        inv_en = 0; inv_index = 0; inv_all = 0;
        tick();
        tick();
        chk("rst_ready", ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_hit", hit, 0);
        chk("rst_hit_way", hit_way, 0);
        chk("rst_victim", victim_way, 0);
        reset = 1'b0;
        wait_ready("sweep_len_reset");

        lookup(6'd9, 20'h0);
        chk("cold_hit", hit, 0);
        chk("cold_victim", victim_way, 0);
        tick();
        chk("idle_rd_valid", rd_valid, 0);

        fill(6'd5, 1'b0, 20'h12345, L0);
        lookup(6'd5, 20'h12345);
        chk("f0_hit", hit, 1);
        chk("f0_way", hit_way, 0);
        chk("f0_line", rd_line, L0);
        chk("f0_victim", victim_way, 1);
        lookup(6'd5, 20'h12346);
        chk("f0_miss", hit, 0);

        fill(6'd5, 1'b1, 20'hABCDE, L1);
        lookup(6'd5, 20'hABCDE);
        chk("f1_hit", hit, 1);
        chk("f1_way", hit_way, 1);
        chk("f1_line", rd_line, L1);
        chk("f1_victim", victim_way, 0);

        // read-first: lookup and overwrite of way 0 in the same cycle
        fill_en = 1'b1; fill_index = 6'd5; fill_way = 1'b0;
        fill_tag = 20'h00001; fill_line = L2;
        lookup(6'd5, 20'h12345);
        fill_en = 1'b0;
        chk("rf_hit", hit, 1);
        chk("rf_way", hit_way, 0);
        chk("rf_line", rd_line, L0);
        lookup(6'd5, 20'h12345);
        chk("rf_after_miss", hit, 0);
        lookup(6'd5, 20'h00001);
        chk("rf_new_hit", hit, 1);
        chk("rf_new_line", rd_line, L2);
        chk("rf_new_victim", victim_way, 1);

        inv_en = 1'b1; inv_index = 6'd5;
        tick();
        inv_en = 1'b0;
        lookup(6'd5, 20'hABCDE);
        chk("inv_miss1", hit, 0);
        chk("inv_keep_ptr", victim_way, 1);
        lookup(6'd5, 20'h00001);
        chk("inv_miss0", hit, 0);

        // fill and invalidate of the same set: invalidate wins
        fill_en = 1'b1; fill_index = 6'd7; fill_way = 1'b0;
        fill_tag = 20'h77777; fill_line = L1;
        inv_en = 1'b1; inv_index = 6'd7;
        tick();
        fill_en = 1'b0; inv_en = 1'b0;
        lookup(6'd7, 20'h77777);
        chk("fi_same_miss", hit, 0);
        chk("fi_same_victim", victim_way, 1);

        // different sets: both apply
        fill(6'd8, 1'b1, 20'h88888, L2);
        fill_en = 1'b1; fill_index = 6'd9; fill_way = 1'b0;
        fill_tag = 20'h99999; fill_line = L0;
        inv_en = 1'b1; inv_index = 6'd8;
        tick();
        fill_en = 1'b0; inv_en = 1'b0;
        lookup(6'd8, 20'h88888);
        chk("fi_diff_inv", hit, 0);
        lookup(6'd9, 20'h99999);
        chk("fi_diff_fill", hit, 1);
        chk("fi_diff_line", rd_line, L0);

        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        chk("ia_ready", ready, 0);
        lookup_en = 1'b1; lookup_index = 6'd9; lookup_tag = 20'h99999;
        tick();
        lookup_en = 1'b0;
        chk("ia_lookup_ignored", rd_valid, 0);
        begin
            int n = 1;
            while (!ready && n < 200) begin
                tick();
                n++;
            end
            chk("sweep_len_inv_all", n, 64);
        end
        lookup(6'd9, 20'h99999);
        chk("ia_miss9", hit, 0);
        lookup(6'd5, 20'h00001);
        chk("ia_miss5", hit, 0);
        chk("ia_victim_clr", victim_way, 0);

        // reset in the middle of a lookup
        lookup_en = 1'b1; lookup_index = 6'd1; reset = 1'b1;
        tick();
        reset = 1'b0; lookup_en = 1'b0;
        chk("rl_rd_valid", rd_valid, 0);
        chk("rl_ready", ready, 0);
        wait_ready("sweep_len_rst2");

`ifdef ICACHE_PERF_CNT_EN
        fill(6'd1, 1'b0, 20'h00011, L0);
        for (int i = 0; i < 3; i++) lookup(6'd1, 20'h00011);
        for (int i = 0; i < 2; i++) lookup(6'd1, 20'h00022);
        tick();
        chk("pc_hits", hit_cnt, 3);
        chk("pc_misses", miss_cnt, 2);
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        chk("pc_hits_clr", hit_cnt, 0);
        chk("pc_misses_clr", miss_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/icache_way_ram.md
Name: icache_way_ram

Overview:
- Parametrised N-way set-associative instruction-cache storage array: tag, data and valid arrays per way, with registered lookup and hit detection.
- Per-set round-robin victim selection.
- Hardware invalidate sweep, used at reset and on demand.
- Sits between the ICache controller FSM and the refill path. Replaces the single-way tag/data/valid store with fixed 64 lines.

Parameters:
INDEX_SIZE, 6, set index width; SETS = 2**INDEX_SIZE
WORD_OFF_SIZE, 4, word offset width; LINE_BITS = 32*2**WORD_OFF_SIZE
TAG_SIZE, 20, tag width; must equal 32-INDEX_SIZE-WORD_OFF_SIZE-2
WAYS, 2, associativity; power of two, 1..8; WAY_BITS = max(1, clog2(WAYS))

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
ready  out  1  array accepting lookup/fill/inv_en; low during sweep
lookup_en  in  1  lookup request
lookup_index  in  INDEX_SIZE  set to read
lookup_tag  in  TAG_SIZE  tag to compare
rd_valid  out  1  lookup result valid (one cycle after accepted lookup)
hit  out  1  tag match on a valid way
hit_way  out  WAY_BITS  matching way
rd_line  out  LINE_BITS  data line of hit_way
victim_way  out  WAY_BITS  round-robin pointer of looked-up set
fill_en  in  1  refill write
fill_index  in  INDEX_SIZE  refill set
fill_way  in  WAY_BITS  refill way (normally the victim_way returned earlier)
fill_tag  in  TAG_SIZE  refill tag
fill_line  in  LINE_BITS  refill data
inv_en  in  1  invalidate all ways of inv_index
inv_index  in  INDEX_SIZE  set to invalidate
inv_all  in  1  pulse: start full invalidate sweep

Behaviour:
- Reset values:
  - ready=0, rd_valid=0, hit=0, hit_way=0, victim_way=0
  - FSM=SWEEP, sweep counter=0
  - Tag and data arrays are not reset.
  - rd_line is don't-care whenever rd_valid=0.
- FSM states:
  - SWEEP: each cycle clears valid of all ways and the victim pointer of set = counter, then increments the counter. When counter==SETS-1 it clears that set and moves to IDLE next cycle. The first ready=1 cycle is reset release + SETS cycles.
  - IDLE: ready=1.
  - inv_all in IDLE: enter SWEEP next cycle with counter=0; ready=0 from next cycle.
  - inv_all in SWEEP: restart counter at 0.
- Lookup:
  - Accepted when ready && lookup_en at edge N.
  - At edge N+1: rd_valid=1, hit/hit_way/rd_line/victim_way registered. Fixed latency of 1.
  - Otherwise rd_valid=0 the next cycle.
  - hit = OR over ways of (valid && tag==lookup_tag).
  - hit_way = lowest matching way. Multiple matches are illegal; the lowest index wins.
  - On a miss, hit_way=0 and rd_line is don't-care.
- Fill (ready && fill_en):
  - Writes fill_tag and fill_line into fill_way of fill_index and sets its valid.
  - Sets the set's victim pointer to (fill_way+1) mod WAYS.
  - WAYS=1: pointer stays 0.
- inv_en (ready): clears valid of all ways of inv_index. The pointer is unchanged.
- Simultaneous events:
  - Priority: reset > inv_all > fill/inv_en.
  - fill_en and inv_en on the same index in the same cycle: tag/data written, valid ends 0.
  - Different indices: both apply.
  - Lookup of a set written in the same cycle returns pre-write contents (read-first).
  - fill_en, inv_en and lookup_en while ready=0 are ignored (no state change).
- Reset asserted mid-sweep or mid-lookup: restarts the sweep from 0 and forces rd_valid=0 next cycle.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- When defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Each rd_valid cycle increments hit_cnt if hit, else miss_cnt.
  - Both counters saturate at 32'hFFFFFFFF and clear to 0 on reset or accepted inv_all.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset 1 cycle, WAYS=2, INDEX_SIZE=6 -> ready=0 for exactly 64 cycles after release, then 1. Lookup of any index -> rd_valid=1, hit=0, victim_way=0.
- Fill idx 5 way 0 tag 0x12345 line L0; lookup idx 5 tag 0x12345 -> next cycle hit=1, hit_way=0, rd_line=L0, victim_way=1. Lookup tag 0x12346 -> hit=0.
- Fill idx 5 way 1 tag 0xABCDE line L1 -> victim_way=0 on next lookup of idx 5. Lookup 0xABCDE -> hit_way=1, rd_line=L1.
- Lookup idx 5 tag 0x12345 in the same cycle as fill idx 5 way 0 tag 0x00001 -> returns hit=1 (old contents). A following lookup of 0x12345 -> hit=0.
- inv_en idx 5 -> both tags miss; fill idx 7 plus inv_en idx 7 in the same cycle -> lookup idx 7 misses. inv_all -> ready low 64 cycles, all sets miss afterwards.
- With ICACHE_PERF_CNT_EN: 3 hits + 2 misses -> hit_cnt=3, miss_cnt=2. inv_all -> both 0.
